// File: rtl/sram_mem_responder.sv
// sram_mem_responder: responder end of the SRAM-like request/response bus.
// Pipelined read/write requests are serviced from an internal word-addressed
// RAM. In-order responses come back after LATENCY cycles, with at most DEPTH
// transactions outstanding.
// Optional build macro MEM_RESP_STALL_EN adds LFSR-driven pseudo-random
// backpressure on addr_ok.
module sram_mem_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = 4;
  localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(LATENCY - 1);
  // With a single cycle of latency the response is registered on the
  // acceptance edge itself, so the queue is never occupied.
  localparam bit BYPASS = (LATENCY == 1);

  logic [31:0]       ram_q [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] idx;
  logic [31:0]       ram_rd;
  logic [31:0]       resp_data;
  logic [31:0]       lane_mask;
  logic              not_full;
  logic              accept;
  logic              push;
  logic              pop;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [31:0]       snap_q [DEPTH];
  logic [31:0]       snap_d [DEPTH];
  logic [TMR_W-1:0]  tmr_q [DEPTH];
  logic [TMR_W-1:0]  tmr_d [DEPTH];
  logic              data_ok_q, data_ok_d;
  logic [31:0]       rdata_q, rdata_d;

  // size is informational and the high/low address bits alias away.
  logic unused_bits;
  assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

  assign idx       = addr[ADDR_W+1:2];
  assign ram_rd    = ram_q[idx];
  assign resp_data = wr ? 32'h0 : ram_rd;
  assign not_full  = (cnt_q < CNT_W'(DEPTH));

`ifdef MEM_RESP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, stepped every cycle.
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  // LFSR state register, reseeded on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 16'hACE1;
    else      lfsr_q <= lfsr_d;
  end

  assign addr_ok = rst & not_full & lfsr_q[0];
`else
  assign addr_ok = rst & not_full;
`endif

  assign accept = req & addr_ok;
  assign push   = accept & ~BYPASS;
  // The head retires on the edge where its countdown reaches zero.
  assign pop    = (cnt_q != '0) && (tmr_q[rd_ptr_q] <= TMR_W'(1));

  // Byte-lane mask for writes.
  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < 4; b++) begin
      lane_mask[8*b +: 8] = {8{wstrb[b]}};
    end
  end

  // Response queue: countdown of valid entries, push, pop and response strobe.
  always_comb begin
    snap_d    = snap_q;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    data_ok_d = 1'b0;
    rdata_d   = rdata_q;

    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] off;
      off = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, off} < cnt_q) && (tmr_q[i] != '0)) begin
        tmr_d[i] = tmr_q[i] - TMR_W'(1);
      end
    end

    if (pop) begin
      data_ok_d = 1'b1;
      rdata_d   = snap_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
    end

    if (push) begin
      snap_d[wr_ptr_q] = resp_data;
      tmr_d[wr_ptr_q]  = TMR_INIT;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end

    if (BYPASS && accept) begin
      data_ok_d = 1'b1;
      rdata_d   = resp_data;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control and response registers; reset flushes pending responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

  // Queue payload storage; only meaningful for entries counted valid.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
    tmr_q  <= tmr_d;
  end

  // RAM write port: commits on the acceptance edge, masked per byte lane.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      ram_q[idx] <= (ram_q[idx] & ~lane_mask) | (wdata & lane_mask);
    end
  end

  assign data_ok = data_ok_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_sram_mem_responder.sv
// Bench for sram_mem_responder: one instance at LATENCY=2 and one at
// LATENCY=6 (both DEPTH=4), driven by a directed sequence with a
// response scoreboard per instance.
module tb_sram_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0, wr0, req1, wr1;
  logic [1:0]  size0, size1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [3:0]  wstrb0, wstrb1;
  logic        addr_ok0, data_ok0, addr_ok1, data_ok1;
  logic [31:0] rdata0, rdata1;

  sram_mem_responder #(.ADDR_W(12), .LATENCY(2), .DEPTH(4)) u_l2 (
    .clk(clk), .rst(rst), .req(req0), .wr(wr0), .size(size0), .addr(addr0),
    .wstrb(wstrb0), .wdata(wdata0), .addr_ok(addr_ok0), .data_ok(data_ok0),
    .rdata(rdata0));

  sram_mem_responder #(.ADDR_W(12), .LATENCY(6), .DEPTH(4)) u_l6 (
    .clk(clk), .rst(rst), .req(req1), .wr(wr1), .size(size1), .addr(addr1),
    .wstrb(wstrb1), .wdata(wdata1), .addr_ok(addr_ok1), .data_ok(data_ok1),
    .rdata(rdata1));

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int pulses0 = 0;
  int pulses1 = 0;

  logic [31:0] expd0[$];
  logic [31:0] expd1[$];
  int          expc0[$];
  int          expc1[$];
  logic [31:0] m0[int];
  logic [31:0] m1[int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Response monitors: every data_ok pulse must match the oldest expectation.
  always @(negedge clk) begin
    logic [31:0] ed;
    int ec;
    if (data_ok0 === 1'b1) begin
      pulses0++;
      chk("resp0_expected", 32'(expd0.size() != 0), 32'd1);
      if (expd0.size() != 0) begin
        ed = expd0.pop_front();
        ec = expc0.pop_front();
        chk("resp0_rdata", rdata0, ed);
        chk("resp0_cycle", 32'(cyc), 32'(ec));
      end
    end
    if (data_ok1 === 1'b1) begin
      pulses1++;
      chk("resp1_expected", 32'(expd1.size() != 0), 32'd1);
      if (expd1.size() != 0) begin
        ed = expd1.pop_front();
        ec = expc1.pop_front();
        chk("resp1_rdata", rdata1, ed);
        chk("resp1_cycle", 32'(cyc), 32'(ec));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req0 = 1'b0;
      req1 = 1'b0;
    end
  endtask

  // Present one request to instance k, hold it until accepted (bounded),
  // and record the expected response in the scoreboard.
  task automatic issue(input int k, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d,
                       output int acc, output logic stalled);
    int tries;
    int idx;
    logic ok;
    logic [31:0] old, mask, e;
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
    if (k == 0) begin
      wr0 = w; addr0 = a; wstrb0 = s; wdata0 = d; size0 = 2'd2; req0 = 1'b1;
    end else begin
      wr1 = w; addr1 = a; wstrb1 = s; wdata1 = d; size1 = 2'd2; req1 = 1'b1;
    end
    #1;
    ok = (k == 0) ? addr_ok0 : addr_ok1;
    stalled = !ok;
    tries = 0;
    while (!ok && tries < 40) begin
      @(negedge clk);
      #1;
      tries++;
      ok = (k == 0) ? addr_ok0 : addr_ok1;
    end
    acc = cyc;
    chk("issue_accepted", {31'd0, ok}, 32'd1);
    if (ok) begin
      idx = int'(a[13:2]);
      for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{s[b]}};
      e = 32'h0;
      if (k == 0) begin
        if (w) begin
          old = m0.exists(idx) ? m0[idx] : 32'h0;
          m0[idx] = (old & ~mask) | (d & mask);
        end else e = m0.exists(idx) ? m0[idx] : 32'h0;
        expd0.push_back(e);
        expc0.push_back(cyc + 2);
      end else begin
        if (w) begin
          old = m1.exists(idx) ? m1[idx] : 32'h0;
          m1[idx] = (old & ~mask) | (d & mask);
        end else e = m1.exists(idx) ? m1[idx] : 32'h0;
        expd1.push_back(e);
        expc1.push_back(cyc + 6);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c1, p;
    logic st;

    // Reset held with requests asserted on both instances.
    rst = 1'b0;
    req0 = 1'b1; wr0 = 1'b1; size0 = 2'd2; addr0 = 32'h20; wstrb0 = 4'hF; wdata0 = 32'h55;
    req1 = 1'b1; wr1 = 1'b1; size1 = 2'd2; addr1 = 32'h20; wstrb1 = 4'hF; wdata1 = 32'h55;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_addr_ok0", {31'd0, addr_ok0}, 32'd0);
      chk("rst_data_ok0", {31'd0, data_ok0}, 32'd0);
      chk("rst_rdata0", rdata0, 32'd0);
      chk("rst_addr_ok1", {31'd0, addr_ok1}, 32'd0);
    end
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    #1;
    chk("rel_addr_ok0", {31'd0, addr_ok0}, 32'd1);
    chk("rel_addr_ok1", {31'd0, addr_ok1}, 32'd1);

    // Word write then read, consecutive cycles.
    issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, c1, st);
    issue(0, 1'b0, 32'h10, 4'h0, 32'h0, c, st);
    chk("wr_rd_back_to_back", 32'(c), 32'(c1 + 1));
    idle(4);

    // Single byte-lane write.
    issue(0, 1'b1, 32'h10, 4'b0010, 32'h0000AA00, c, st);
    issue(0, 1'b0, 32'h10, 4'h0, 32'h0, c, st);
    idle(4);

    // Address aliasing above the word index and in the byte offset.
    issue(0, 1'b1, 32'h4000, 4'hF, 32'h12345678, c, st);
    issue(0, 1'b0, 32'h0000, 4'h0, 32'h0, c, st);
    issue(0, 1'b0, 32'h4003, 4'h0, 32'h0, c, st);
    idle(4);

    // Full throughput at LATENCY=2, DEPTH=4.
    issue(0, 1'b1, 32'h20, 4'hF, 32'h11111111, c1, st);
    for (int i = 0; i < 8; i++) begin
      issue(0, 1'b0, (i % 3 == 0) ? 32'h10 : ((i % 3 == 1) ? 32'h0 : 32'h20), 4'h0, 32'h0, c, st);
      chk("tput_cycle", 32'(c), 32'(c1 + i + 1));
      chk("tput_stall", {31'd0, st}, 32'd0);
    end
    idle(4);

    // Prepare LATENCY=6 instance contents.
    issue(1, 1'b1, 32'h100, 4'hF, 32'hA0A00001, c, st);
    issue(1, 1'b1, 32'h104, 4'hF, 32'hB0B00002, c, st);
    issue(1, 1'b1, 32'h108, 4'hF, 32'hC0C00003, c, st);
    issue(1, 1'b1, 32'h10C, 4'hF, 32'hD0D00004, c, st);
    issue(1, 1'b1, 32'h10, 4'hF, 32'hDEADAAEF, c, st);
    idle(12);

    // Backpressure: five back-to-back reads against DEPTH=4.
    p = pulses1;
    issue(1, 1'b0, 32'h100, 4'h0, 32'h0, c1, st);
    chk("bp_first_stall", {31'd0, st}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      issue(1, 1'b0, 32'h100 + 32'(4 * i), 4'h0, 32'h0, c, st);
      chk("bp_fill_cycle", 32'(c), 32'(c1 + i));
    end
    issue(1, 1'b0, 32'h10, 4'h0, 32'h0, c, st);
    chk("bp_fifth_stalled", {31'd0, st}, 32'd1);
    chk("bp_fifth_cycle", 32'(c), 32'(c1 + 6));
    idle(12);
    chk("bp_pulse_count", 32'(pulses1 - p), 32'd5);

    // Reset mid-flight with two reads pending and a write attempted during reset.
    issue(1, 1'b0, 32'h100, 4'h0, 32'h0, c, st);
    issue(1, 1'b0, 32'h104, 4'h0, 32'h0, c, st);
    @(negedge clk);
    #1;
    rst = 1'b0;
    expd0.delete(); expc0.delete(); expd1.delete(); expc1.delete();
    req1 = 1'b0;
    wr0 = 1'b1; addr0 = 32'h20; wstrb0 = 4'hF; wdata0 = 32'h55; req0 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("midrst_addr_ok0", {31'd0, addr_ok0}, 32'd0);
      chk("midrst_data_ok1", {31'd0, data_ok1}, 32'd0);
    end
    rst = 1'b1;
    req0 = 1'b0;
    p = pulses1;
    idle(10);
    chk("midrst_no_stale", 32'(pulses1 - p), 32'd0);
    issue(1, 1'b0, 32'h10, 4'h0, 32'h0, c, st);
    issue(0, 1'b0, 32'h20, 4'h0, 32'h0, c, st);
    idle(10);

    chk("scoreboard_drained", 32'(expd0.size() + expd1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
